// File: rtl/mecobo_pkg.sv
// Shared definitions for the sample sequencer.
//   - Command register offsets (relative to BASE_ADDR) and control bit fields.
//   - Sequencer FSM state encoding.
//   - find_channel(): lowest set mask bit at or above a start index.
package mecobo_pkg;

   localparam int unsigned REG_MASK_LO    = 0;
   localparam int unsigned REG_MASK_HI    = 1;
   localparam int unsigned REG_CTRL       = 2;

   localparam int unsigned CTRL_RUN_BIT   = 0;
   localparam int unsigned CTRL_CLEAR_BIT = 1;
   localparam int unsigned CTRL_DIV_LSB   = 8;
   localparam int unsigned CTRL_DIV_MSB   = 23;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_SELECT  = 2'd2,
      ST_CAPTURE = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic       found;
      logic [5:0] idx;
   } chan_pick_t;

   function automatic chan_pick_t find_channel(input logic [63:0] mask,
                                               input logic [6:0]  start);
      chan_pick_t r;
      r.found = 1'b0;
      r.idx   = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (!r.found && mask[i] && (i >= 32'(start))) begin
            r.found = 1'b1;
            r.idx   = 6'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sample_sequencer_if.sv
// Command bus and wired-OR sample bus of the sample sequencer.
//   addr/cmd_data_in/cs/wr : register writes (write when cs & wr)
//   output_sample          : one-cycle strobe to the channel units
//   channel_select         : channel addressed by the strobe
//   sample_data            : channel reply, valid the cycle after the strobe
// slave  : the sequencer side.
// master : the host / channel-unit side.
interface sample_sequencer_if;
   logic [15:0] addr;
   logic [31:0] cmd_data_in;
   logic        cs;
   logic        wr;
   logic        output_sample;
   logic [7:0]  channel_select;
   logic [31:0] sample_data;

   modport slave  (input  addr, cmd_data_in, cs, wr, sample_data,
                   output output_sample, channel_select);
   modport master (output addr, cmd_data_in, cs, wr, sample_data,
                   input  output_sample, channel_select);
endinterface

// File: rtl/sample_fifo_sync.sv
// Single-clock 32-bit sample FIFO.
//   clk, rst         : clock, synchronous active-high reset
//   clear            : synchronous flush, overrides push/pop in the same cycle
//   push, push_data  : write port (ignored when full)
//   pop, head        : read port, head is the oldest entry (ignored when empty)
//   count, full, empty : occupancy status
module sample_fifo_sync #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [31:0]              push_data,
   input  logic                     pop,
   output logic [31:0]              head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] cnt_t;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == cnt_t'(DEPTH));
   assign empty = (count == '0);
   assign do_wr = push && !full && !clear && !rst;
   assign do_rd = pop && !empty && !clear;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + cnt_t'(1);
            2'b01:   count <= count - cnt_t'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sample_sequencer.sv
// Sample sequencer: periodically sweeps the enabled channels over the
// wired-OR sample bus and queues each 32-bit reply in a FIFO that the EBI
// reads out as 16-bit half-words (low half first).
//   clk, rst                 : 75 MHz clock, synchronous active-high reset
//   bus (slave)              : command bus + sample bus
//   global_clock_running     : sampling gate
//   sample_fifo_rd_en        : EBI half-word read strobe
//   sample_data_out          : current half-word (0 when empty)
//   sample_fifo_* / overflow / drop_count : FIFO status
module sample_sequencer
   import mecobo_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 64,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned BASE_ADDR    = 232
) (
   input  logic              clk,
   input  logic              rst,
   sample_sequencer_if.slave bus,
   input  logic              global_clock_running,
   input  logic              sample_fifo_rd_en,
   output logic [15:0]       sample_data_out,
   output logic              sample_fifo_empty,
   output logic              sample_fifo_almost_empty,
   output logic              sample_fifo_full,
   output logic              sample_fifo_almost_full,
   output logic [15:0]       sample_fifo_data_count,
   output logic              overflow,
   output logic [15:0]       drop_count
);
   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] cnt_t;

   localparam logic [63:0] CHAN_MASK = (64'd1 << NUM_CHANNELS) - 64'd1;
   localparam logic [15:0] A_MASK_LO = 16'(BASE_ADDR + REG_MASK_LO);
   localparam logic [15:0] A_MASK_HI = 16'(BASE_ADDR + REG_MASK_HI);
   localparam logic [15:0] A_CTRL    = 16'(BASE_ADDR + REG_CTRL);

   logic [63:0] mask_reg;
   logic [15:0] div_reg;
   logic        run_reg;
   logic [63:0] eff_mask;
   logic        wr_en;
   logic        clr;

   seq_state_t  state;
   logic [15:0] div_cnt;
   logic [5:0]  ch;
   chan_pick_t  pick_first;
   chan_pick_t  pick_next;
   logic        go;

   logic        push;
   logic        pop;
   logic        half;
   logic [31:0] head;
   cnt_t        fifo_count;
   logic        fifo_full;
   logic        fifo_empty;

   // ---------------- command registers ----------------
   assign wr_en    = bus.cs && bus.wr;
   assign clr      = wr_en && (bus.addr == A_CTRL) && bus.cmd_data_in[CTRL_CLEAR_BIT];
   assign eff_mask = mask_reg & CHAN_MASK;

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_reg <= '0;
         div_reg  <= '0;
         run_reg  <= 1'b0;
      end else if (wr_en) begin
         if (bus.addr == A_MASK_LO) mask_reg[31:0]  <= bus.cmd_data_in;
         if (bus.addr == A_MASK_HI) mask_reg[63:32] <= bus.cmd_data_in;
         if (bus.addr == A_CTRL) begin
            div_reg <= bus.cmd_data_in[CTRL_DIV_MSB:CTRL_DIV_LSB];
            run_reg <= bus.cmd_data_in[CTRL_RUN_BIT];
         end
      end
   end

   // ---------------- sweep FSM ----------------
   // Channel search uses the live mask, so mask writes land at the next advance.
   assign pick_first = find_channel(eff_mask, 7'd0);
   assign pick_next  = find_channel(eff_mask, {1'b0, ch} + 7'd1);
   assign go         = run_reg && global_clock_running && pick_first.found;

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_IDLE;
         div_cnt            <= '0;
         ch                 <= '0;
         bus.output_sample  <= 1'b0;
         bus.channel_select <= '0;
      end else begin
         bus.output_sample  <= 1'b0;
         bus.channel_select <= '0;
         case (state)
            ST_IDLE: begin
               if (go) begin
                  div_cnt <= div_reg;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!go) begin
                  state <= ST_IDLE;
               end else if (div_cnt == '0) begin
                  ch                 <= pick_first.idx;
                  bus.output_sample  <= 1'b1;
                  bus.channel_select <= {2'b00, pick_first.idx};
                  state              <= ST_SELECT;
               end else begin
                  div_cnt <= div_cnt - 16'd1;
               end
            end
            ST_SELECT: state <= ST_CAPTURE;
            ST_CAPTURE: begin
               if (pick_next.found) begin
                  ch                 <= pick_next.idx;
                  bus.output_sample  <= 1'b1;
                  bus.channel_select <= {2'b00, pick_next.idx};
                  state              <= ST_SELECT;
               end else if (run_reg && global_clock_running) begin
                  div_cnt <= div_reg;
                  state   <= ST_WAIT;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The FIFO write edge is the end of CAPTURE, so the bus value present
   // during CAPTURE is what gets stored.
   assign push = (state == ST_CAPTURE);

   // ---------------- FIFO and read side ----------------
   assign pop = sample_fifo_rd_en && !fifo_empty && half;

   sample_fifo_sync #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (clr),
      .push      (push),
      .push_data (bus.sample_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         half       <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (sample_fifo_rd_en && !fifo_empty) half <= ~half;
         if (push && fifo_full) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
      end
   end

   assign sample_data_out          = fifo_empty ? '0 : (half ? head[31:16] : head[15:0]);
   assign sample_fifo_empty        = fifo_empty;
   assign sample_fifo_full         = fifo_full;
   assign sample_fifo_almost_empty = (fifo_count <= cnt_t'(1));
   assign sample_fifo_almost_full  = (fifo_count >= cnt_t'(DEPTH - 2));
   assign sample_fifo_data_count   = 16'(fifo_count);

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 64, number of scanned sample channels (1..64).
REQ-002 SHALL have parameter DEPTH, default 1024, sample FIFO depth in 32-bit entries (power of 2, >=4).
REQ-003 SHALL have parameter BASE_ADDR, default 232, command-bus base address.
REQ-004 SHALL have ports: clk in 1 system clock (75 MHz); rst in 1 synchronous active-high reset.
REQ-005 SHALL have ports: addr in 16, cmd_data_in in 32, cs in 1, wr in 1, which form the command bus (write when cs&wr).
REQ-006 SHALL have ports: output_sample out 1, channel_select out 8, sample_data in 32, which form the wired-OR sample bus to the channel units.
REQ-007 SHALL have port global_clock_running in 1, which is the sampling gate.
REQ-008 SHALL have ports: sample_fifo_rd_en in 1, sample_data_out out 16 (EBI read side).
REQ-009 SHALL have status outputs: sample_fifo_empty, _almost_empty, _full, _almost_full out 1 each; sample_fifo_data_count out 16; overflow out 1; drop_count out 16.

Function
REQ-010 Register writes SHALL be: BASE+0 mask[31:0]; BASE+1 mask[63:32]; BASE+2 control {div[23:8], clear[1], run[0]}; mask bits >= NUM_CHANNELS are ignored.
REQ-011 A write of clear=1 SHALL empty the FIFO, reset half-word pointer, overflow and drop_count within 1 cycle; clear is self-clearing and takes priority over a same-cycle push/pop.
REQ-012 The FSM SHALL have states IDLE, WAIT, SELECT, CAPTURE.
REQ-013 In IDLE, when run&global_clock_running&(mask!=0), the FSM SHALL load the divider counter with div and go to WAIT.
REQ-014 WAIT SHALL decrement the divider each cycle; at 0 it SHALL set ch = lowest enabled channel and go to SELECT (div=0 gives back-to-back sweeps).
REQ-015 SELECT SHALL drive channel_select=ch and output_sample=1 for exactly one cycle, then go to CAPTURE.
REQ-016 CAPTURE SHALL register sample_data (the bus value one cycle after output_sample) and push it; then SELECT the next higher enabled channel, or, after the highest, return to WAIT (reloading div), or to IDLE if run or global_clock_running has dropped.
REQ-017 Dropping run/global_clock_running SHALL not abort an in-progress SELECT/CAPTURE pair; the sweep ends after that capture.
REQ-018 When not in SELECT, output_sample SHALL be 0 and channel_select SHALL be 0.
REQ-019 A push while full SHALL drop the sample, set sticky overflow, and increment drop_count, which saturates at 0xFFFF.
REQ-020 The read side SHALL present the low half of the head entry on sample_data_out when half=0 and the high half when half=1; sample_data_out SHALL be 0 when empty.
REQ-021 sample_fifo_rd_en with half=0 SHALL set half=1; with half=1 it SHALL clear half and pop the entry; rd_en when empty SHALL be ignored.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 data_count SHALL be the entry count, zero-extended to 16 bits; almost_empty SHALL be count<=1; almost_full SHALL be count>=DEPTH-2; full SHALL be count==DEPTH.
REQ-024 Mask/div writes during a sweep SHALL take effect at the next channel advance / next WAIT reload respectively.

Reset
REQ-025 On rst the block SHALL enter IDLE with mask=0, div=0, run=0, FIFO empty, half=0, overflow=0, drop_count=0, output_sample=0, channel_select=0, sample_data_out=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-026 rst mid-sweep SHALL deassert output_sample on the next edge and discard any uncommitted capture.

Structure
REQ-027 Register offsets, control bit positions and the FSM state encoding SHALL live in shared package mecobo_pkg.
REQ-028 Storage SHALL be one sub-module, sample_fifo_sync (single-clock, parameter DEPTH, width 32, count output).

Verification
REQ-029 Test: mask=0x5, div=0, run=1, clock running, channel 0 drives 0x11112222 and channel 2 drives 0x33334444 -> output_sample pulses with channel_select 0 then 2, and reads return 0x2222, 0x1111, 0x4444, 0x3333.
REQ-030 Test: div=3, mask=0x1 -> output_sample pulses 6 cycles apart (1 SELECT + 1 CAPTURE + 4 WAIT).
REQ-031 Test: fill to DEPTH with no reads, then 3 more captures -> full=1, overflow=1, drop_count=3, and data_count=DEPTH.
REQ-032 Test: same-cycle push and second-half rd_en at count=5 -> count stays 5; rd_en on empty -> no change, sample_data_out=0.
REQ-033 Test: clear written while count=10 and a capture is pending -> count=0, overflow=0, empty=1 the next cycle.
REQ-034 Test: rst asserted during SELECT -> output_sample=0 next cycle and all REQ-025 values hold.
